// File: rtl/mul_pkg.sv
// Shared definitions for the multiply functional-unit controller.
// Default operand and tag widths, the stage record and the minimum legal latency.
package mul_pkg;

  localparam int unsigned MUL_XLEN        = 32;
  localparam int unsigned MUL_TAG_W       = 4;
  localparam int unsigned MUL_MIN_LATENCY = 2;

  typedef struct packed {
    logic                 valid;
    logic [MUL_TAG_W-1:0] tag;
    logic                 hi;
    logic [MUL_XLEN-1:0]  data;
  } mul_stage_t;

endpackage

// File: rtl/mul_pipe_stage.sv
// One elastic register stage: loads when empty or when its content moves downstream.
// A flush clears the valid flag; the payload may keep stale contents.
module mul_pipe_stage
  import mul_pkg::*;
#(
  parameter int unsigned W = MUL_XLEN
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_flush,
  input  logic         i_valid,
  input  logic [W-1:0] i_data,
  input  logic         i_ready,
  output logic         o_valid,
  output logic [W-1:0] o_data
);

  logic         r_valid;
  logic [W-1:0] r_data;
  logic         w_load;

  assign w_load = !r_valid | i_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
    end else if (w_load) begin
      r_valid <= i_valid;
      if (i_valid) begin
        r_data <= i_data;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/mul_fu_ctrl.sv
// Multiply functional-unit controller: operand stage S0 feeds the external Wallace
// multiplier, LATENCY-1 elastic stages carry {tag, result half} to the CDB.
module mul_fu_ctrl
  import mul_pkg::*;
#(
  parameter int unsigned XLEN    = MUL_XLEN,
  parameter int unsigned TAG_W   = MUL_TAG_W,
  parameter int unsigned LATENCY = 3
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           flush,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [TAG_W-1:0]               in_tag,
  input  logic [XLEN-1:0]                in_a,
  input  logic [XLEN-1:0]                in_b,
  input  logic                           in_hi,
  output logic [XLEN-1:0]                mul_a,
  output logic [XLEN-1:0]                mul_b,
  input  logic [2*XLEN-1:0]              mul_prod,
  output logic                           cdb_req,
  input  logic                           cdb_grant,
  output logic [TAG_W-1:0]               cdb_tag,
  output logic [XLEN-1:0]                cdb_data,
  output logic [$clog2(LATENCY+1)-1:0]   busy_cnt,
  output logic [31:0]                    done_cnt
);

  localparam int unsigned PW    = TAG_W + XLEN;
  localparam int unsigned CNT_W = $clog2(LATENCY+1);

  if (LATENCY < MUL_MIN_LATENCY) begin : g_bad_latency
    $error("mul_fu_ctrl: LATENCY below minimum");
  end

  logic             r_s0_valid;
  logic [TAG_W-1:0] r_s0_tag;
  logic             r_s0_hi;
  logic [XLEN-1:0]  r_a;
  logic [XLEN-1:0]  r_b;
  logic [31:0]      r_done_cnt;

  logic [LATENCY-1:0] w_v;
  logic [LATENCY:0]   w_rdy;
  logic [PW-1:0]      w_pl [LATENCY];
  logic               w_xfer;
  logic [CNT_W-1:0]   w_busy;

  assign cdb_req = w_v[LATENCY-1] & !flush;
  assign w_xfer  = cdb_req & cdb_grant;

  // Ready chain from the CDB grant back to S0; w_rdy[i] means stage i loads this cycle.
  always_comb begin
    w_rdy          = '0;
    w_rdy[LATENCY] = w_xfer;
    for (int unsigned k = 0; k < LATENCY; k++) begin
      w_rdy[LATENCY-1-k] = !w_v[LATENCY-1-k] | w_rdy[LATENCY-k];
    end
  end

  assign in_ready = w_rdy[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s0_valid <= 1'b0;
      r_s0_tag   <= '0;
      r_s0_hi    <= 1'b0;
      r_a        <= '0;
      r_b        <= '0;
    end else if (flush) begin
      r_s0_valid <= 1'b0;
    end else if (w_rdy[0]) begin
      r_s0_valid <= in_valid;
      if (in_valid) begin
        r_s0_tag <= in_tag;
        r_s0_hi  <= in_hi;
        r_a      <= in_a;
        r_b      <= in_b;
      end
    end
  end

  assign w_v[0] = r_s0_valid;
  assign mul_a  = r_a;
  assign mul_b  = r_b;

  // Result half is chosen here, so later stages only carry XLEN bits.
  assign w_pl[0] = {r_s0_tag, r_s0_hi ? mul_prod[2*XLEN-1:XLEN] : mul_prod[XLEN-1:0]};

  for (genvar i = 1; i < LATENCY; i++) begin : g_stage
    mul_pipe_stage #(
      .W (PW)
    ) u_stage (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_flush (flush),
      .i_valid (w_v[i-1]),
      .i_data  (w_pl[i-1]),
      .i_ready (w_rdy[i+1]),
      .o_valid (w_v[i]),
      .o_data  (w_pl[i])
    );
  end

  assign cdb_tag  = w_pl[LATENCY-1][PW-1:XLEN];
  assign cdb_data = w_pl[LATENCY-1][XLEN-1:0];

  always_comb begin
    w_busy = '0;
    for (int unsigned i = 0; i < LATENCY; i++) begin
      w_busy = w_busy + CNT_W'(w_v[i]);
    end
  end

  assign busy_cnt = w_busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_done_cnt <= '0;
    end else if (w_xfer) begin
      r_done_cnt <= r_done_cnt + 32'd1;
    end
  end

  assign done_cnt = r_done_cnt;

endmodule

// File: tb/tb_mul_fu_ctrl.sv
// Directed self-checking bench for mul_fu_ctrl with a behavioural multiplier
// standing in for the Wallace tree.
module tb_mul_fu_ctrl;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_tag;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        in_hi;
  logic [31:0] mul_a;
  logic [31:0] mul_b;
  logic [63:0] mul_prod;
  logic        cdb_req;
  logic        cdb_grant;
  logic [3:0]  cdb_tag;
  logic [31:0] cdb_data;
  logic [1:0]  busy_cnt;
  logic [31:0] done_cnt;

  int n_cmp;
  int n_bad;

  mul_fu_ctrl #(
    .XLEN    (32),
    .TAG_W   (4),
    .LATENCY (3)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_tag    (in_tag),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_hi     (in_hi),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_prod  (mul_prod),
    .cdb_req   (cdb_req),
    .cdb_grant (cdb_grant),
    .cdb_tag   (cdb_tag),
    .cdb_data  (cdb_data),
    .busy_cnt  (busy_cnt),
    .done_cnt  (done_cnt)
  );

  assign mul_prod = {32'd0, mul_a} * {32'd0, mul_b};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] t, input logic [31:0] a, input logic [31:0] b, input logic h);
    in_valid = 1'b1; in_tag = t; in_a = a; in_b = b; in_hi = h;
    step();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_tag = '0; in_a = '0; in_b = '0;
    in_hi = 1'b0; cdb_grant = 1'b1;
    step(); step();
    n_cmp++; if (cdb_req !== 1'b0) begin $display("FAIL reset_req got=%0b exp=0", cdb_req); n_bad++; end
    n_cmp++; if (busy_cnt !== 2'd0) begin $display("FAIL reset_busy got=%0d exp=0", busy_cnt); n_bad++; end
    n_cmp++; if (done_cnt !== 32'd0) begin $display("FAIL reset_done got=%0d exp=0", done_cnt); n_bad++; end
    n_cmp++; if (mul_a !== 32'd0 || mul_b !== 32'd0) begin $display("FAIL reset_mulab got=%h/%h exp=0/0", mul_a, mul_b); n_bad++; end
    n_cmp++; if (cdb_tag !== 4'd0 || cdb_data !== 32'd0) begin $display("FAIL reset_cdb got=%h/%h exp=0/0", cdb_tag, cdb_data); n_bad++; end
    rst_n = 1'b1;
    step();
    n_cmp++; if (in_ready !== 1'b1) begin $display("FAIL reset_ready got=%0b exp=1", in_ready); n_bad++; end
    n_cmp++; if (done_cnt !== 32'd0) begin $display("FAIL idle_grant_done got=%0d exp=0", done_cnt); n_bad++; end
  endtask

  task automatic test_basic_lo();
    cdb_grant = 1'b1;
    n_cmp++; if (in_ready !== 1'b1) begin $display("FAIL lo_ready got=%0b exp=1", in_ready); n_bad++; end
    issue(4'd5, 32'h00E00003, 32'h0000A000, 1'b0);
    n_cmp++; if (cdb_req !== 1'b0 || busy_cnt !== 2'd1) begin $display("FAIL lo_t1 req=%0b busy=%0d exp req=0 busy=1", cdb_req, busy_cnt); n_bad++; end
    n_cmp++; if (mul_a !== 32'h00E00003 || mul_b !== 32'h0000A000) begin $display("FAIL lo_mulab got=%h/%h exp=00e00003/0000a000", mul_a, mul_b); n_bad++; end
    step();
    n_cmp++; if (cdb_req !== 1'b0) begin $display("FAIL lo_t2 req got=%0b exp=0", cdb_req); n_bad++; end
    step();
    n_cmp++; if (cdb_req !== 1'b1 || cdb_tag !== 4'd5 || cdb_data !== 32'h0001E000) begin
      $display("FAIL lo_t3 req=%0b tag=%0d data=%h exp req=1 tag=5 data=0001e000", cdb_req, cdb_tag, cdb_data); n_bad++; end
    step();
    n_cmp++; if (cdb_req !== 1'b0 || done_cnt !== 32'd1) begin $display("FAIL lo_done req=%0b done=%0d exp req=0 done=1", cdb_req, done_cnt); n_bad++; end
  endtask

  task automatic test_basic_hi();
    issue(4'd6, 32'h00E00003, 32'h0000A000, 1'b1);
    issue(4'd7, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
    issue(4'd8, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    n_cmp++; if (cdb_req !== 1'b1 || cdb_tag !== 4'd6 || cdb_data !== 32'h0000008C) begin
      $display("FAIL hi_a req=%0b tag=%0d data=%h exp req=1 tag=6 data=0000008c", cdb_req, cdb_tag, cdb_data); n_bad++; end
    step();
    n_cmp++; if (cdb_req !== 1'b1 || cdb_tag !== 4'd7 || cdb_data !== 32'hFFFFFFFE) begin
      $display("FAIL hi_max req=%0b tag=%0d data=%h exp req=1 tag=7 data=fffffffe", cdb_req, cdb_tag, cdb_data); n_bad++; end
    step();
    n_cmp++; if (cdb_req !== 1'b1 || cdb_tag !== 4'd8 || cdb_data !== 32'h00000001) begin
      $display("FAIL lo_max req=%0b tag=%0d data=%h exp req=1 tag=8 data=00000001", cdb_req, cdb_tag, cdb_data); n_bad++; end
    step();
    n_cmp++; if (cdb_req !== 1'b0 || done_cnt !== 32'd4) begin $display("FAIL hi_done req=%0b done=%0d exp req=0 done=4", cdb_req, done_cnt); n_bad++; end
  endtask

  task automatic test_streaming();
    for (int i = 0; i < 8; i++) begin
      in_valid = (i < 4); in_tag = 4'(i + 1); in_a = 32'h0000FFFF; in_b = 32'h0000FFFF; in_hi = 1'b0;
      if (i >= 3 && i < 7) begin
        n_cmp++; if (cdb_req !== 1'b1 || cdb_tag !== 4'(i - 2) || cdb_data !== 32'hFFFE0001) begin
          $display("FAIL stream_%0d req=%0b tag=%0d data=%h exp req=1 tag=%0d data=fffe0001", i, cdb_req, cdb_tag, cdb_data, i - 2); n_bad++; end
      end else if (i == 7) begin
        n_cmp++; if (cdb_req !== 1'b0) begin $display("FAIL stream_end req got=%0b exp=0", cdb_req); n_bad++; end
      end
      step();
    end
    in_valid = 1'b0;
    n_cmp++; if (done_cnt !== 32'd8) begin $display("FAIL stream_done got=%0d exp=8", done_cnt); n_bad++; end
  endtask

  task automatic test_backpressure();
    cdb_grant = 1'b0;
    issue(4'd9,  32'h10, 32'd9,  1'b0);
    issue(4'd10, 32'h10, 32'd10, 1'b0);
    issue(4'd11, 32'h10, 32'd11, 1'b0);
    in_valid = 1'b1; in_tag = 4'd12; in_a = 32'h10; in_b = 32'd12; in_hi = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (busy_cnt !== 2'd3 || in_ready !== 1'b0 || cdb_req !== 1'b1 || cdb_tag !== 4'd9 || cdb_data !== 32'h90) begin
        $display("FAIL bp_hold_%0d busy=%0d rdy=%0b req=%0b tag=%0d data=%h exp busy=3 rdy=0 req=1 tag=9 data=90",
                 i, busy_cnt, in_ready, cdb_req, cdb_tag, cdb_data); n_bad++; end
      if (i < 2) step();
    end
    cdb_grant = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin $display("FAIL bp_release_ready got=%0b exp=1", in_ready); n_bad++; end
    step();
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      n_cmp++; if (cdb_req !== 1'b1 || cdb_tag !== 4'(10 + k) || cdb_data !== 32'(16 * (10 + k))) begin
        $display("FAIL bp_drain_%0d req=%0b tag=%0d data=%h exp req=1 tag=%0d data=%h",
                 k, cdb_req, cdb_tag, cdb_data, 10 + k, 32'(16 * (10 + k))); n_bad++; end
      step();
    end
    n_cmp++; if (cdb_req !== 1'b0 || busy_cnt !== 2'd0 || done_cnt !== 32'd12) begin
      $display("FAIL bp_end req=%0b busy=%0d done=%0d exp req=0 busy=0 done=12", cdb_req, busy_cnt, done_cnt); n_bad++; end
  endtask

  task automatic test_flush();
    cdb_grant = 1'b1;
    issue(4'd1, 32'd2, 32'd3, 1'b0);
    issue(4'd2, 32'd2, 32'd4, 1'b0);
    issue(4'd3, 32'd2, 32'd5, 1'b0);
    flush = 1'b1; in_valid = 1'b1; in_tag = 4'd4; in_a = 32'd9; in_b = 32'd9; in_hi = 1'b0;
    #1;
    n_cmp++; if (cdb_req !== 1'b0) begin $display("FAIL flush_req got=%0b exp=0", cdb_req); n_bad++; end
    step();
    flush = 1'b0; in_valid = 1'b0;
    n_cmp++; if (busy_cnt !== 2'd0 || cdb_req !== 1'b0 || done_cnt !== 32'd12) begin
      $display("FAIL flush_after busy=%0d req=%0b done=%0d exp busy=0 req=0 done=12", busy_cnt, cdb_req, done_cnt); n_bad++; end
    step(); step();
    n_cmp++; if (cdb_req !== 1'b0 || done_cnt !== 32'd12) begin $display("FAIL flush_drop req=%0b done=%0d exp req=0 done=12", cdb_req, done_cnt); n_bad++; end
    issue(4'd13, 32'd7, 32'd6, 1'b0);
    step(); step();
    n_cmp++; if (cdb_req !== 1'b1 || cdb_tag !== 4'd13 || cdb_data !== 32'h2A) begin
      $display("FAIL flush_new req=%0b tag=%0d data=%h exp req=1 tag=13 data=0000002a", cdb_req, cdb_tag, cdb_data); n_bad++; end
    step();
    n_cmp++; if (done_cnt !== 32'd13) begin $display("FAIL flush_new_done got=%0d exp=13", done_cnt); n_bad++; end
  endtask

  task automatic test_async_reset();
    cdb_grant = 1'b0;
    issue(4'd2, 32'h1234, 32'h5678, 1'b0);
    issue(4'd3, 32'hABCD, 32'h0101, 1'b0);
    issue(4'd4, 32'h0F0F, 32'h0202, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (cdb_req !== 1'b0 || busy_cnt !== 2'd0 || done_cnt !== 32'd0) begin
      $display("FAIL areset_ctl req=%0b busy=%0d done=%0d exp 0/0/0", cdb_req, busy_cnt, done_cnt); n_bad++; end
    n_cmp++; if (mul_a !== 32'd0 || mul_b !== 32'd0) begin $display("FAIL areset_mulab got=%h/%h exp=0/0", mul_a, mul_b); n_bad++; end
    step();
    rst_n = 1'b1;
    step();
    n_cmp++; if (in_ready !== 1'b1 || cdb_req !== 1'b0) begin $display("FAIL areset_release rdy=%0b req=%0b exp rdy=1 req=0", in_ready, cdb_req); n_bad++; end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_basic_lo();
    test_basic_hi();
    test_streaming();
    test_backpressure();
    test_flush();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mul_fu_ctrl.md
Name: mul_fu_ctrl

Overview:
- Controller for the 32-bit Wallace multiplier functional unit in the Tomasulo core.
- Accepts issued multiply ops (operands plus ROB/RS tag) from the multiply reservation station and drives operands into the combinational Wallace multiplier instance.
- Carries tag, valid and result-half select through an elastic LATENCY-stage pipeline, then requests the common data bus (CDB) and holds the result until granted.
- Supports a squash (flush) and reports occupancy.

Parameters:
- XLEN, 32, operand width; the product is 2*XLEN.
- TAG_W, 4, reservation-station/ROB tag width.
- LATENCY, 3, accept-to-cdb_req cycles; minimum 2.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous squash of all in-flight ops
- in_valid  in  1  issue request
- in_ready  out  1  unit can accept this cycle
- in_tag  in  TAG_W  destination tag
- in_a  in  XLEN  multiplicand
- in_b  in  XLEN  multiplier
- in_hi  in  1  1 = return product[2*XLEN-1:XLEN], 0 = return product[XLEN-1:0]
- mul_a  out  XLEN  registered operand to the Wallace multiplier
- mul_b  out  XLEN  registered operand to the Wallace multiplier
- mul_prod  in  2*XLEN  final product from the multiplier (combinational from mul_a/mul_b)
- cdb_req  out  1  result ready for broadcast
- cdb_grant  in  1  CDB arbiter grant; a transfer occurs when cdb_req & cdb_grant
- cdb_tag  out  TAG_W  tag being broadcast
- cdb_data  out  XLEN  selected result half
- busy_cnt  out  $clog2(LATENCY+1)  number of valid ops in flight
- done_cnt  out  32  completed broadcasts, wraps at 2^32

Behaviour:
- Reset (rst_n low, asynchronous): all stage valids = 0; mul_a, mul_b, cdb_tag, cdb_data = 0; cdb_req = 0; busy_cnt = 0; done_cnt = 0. in_ready = 1 after reset.
- Pipeline structure: stages S0..S(LATENCY-1), each holding {valid, tag, hi, data}.
  - S0 holds operands; mul_a and mul_b come straight from S0 registers.
  - On the S0->S1 transfer, the data field captures mul_prod, selected by hi (slicing happens at S1 capture).
  - Later stages are pure delay.
- Elastic advance: stage i advances (loads from i-1) when stage i is empty or advancing. The last stage advances when cdb_req & cdb_grant. Bubbles collapse.
- in_ready = !S0.valid | S0 advancing. This is combinational from cdb_grant (path accepted).
- Accept happens when in_valid & in_ready at a clock edge. If accepted in cycle t, cdb_req = 1 in cycle t+LATENCY when no stall occurs.
- Back-to-back accepts are allowed every cycle; throughput is 1 op/cycle with no backpressure.
- cdb_req = S(LATENCY-1).valid & !flush. cdb_tag and cdb_data are driven from the last stage and held stable while cdb_req & !cdb_grant.
- cdb_grant with cdb_req low: ignored.
- flush (synchronous, highest priority):
  - Clears every valid at the edge.
  - A same-cycle accept is dropped.
  - cdb_req is forced low that cycle, so no transfer and done_cnt does not increment.
  - Data/tag registers may hold stale values.
- busy_cnt = popcount of stage valids; done_cnt increments on each transfer.
- Full pipeline with stalled CDB: in_ready = 0. When grant arrives, all stages shift the same cycle and in_ready = 1 in that cycle.
- Reset mid-operation discards everything immediately; no output glitches to cdb_req = 1.
- Arithmetic is unsigned only; no rounding or overflow flags.

Decomposition:
- Shared package mul_pkg:
  - XLEN and TAG_W defaults.
  - typedef mul_stage_t {valid, tag, hi, data}.
  - Constant MUL_MIN_LATENCY = 2.
- One sub-module is natural: mul_pipe_stage, a single elastic register stage (valid/ready handshake, flush clear, async reset). It is instantiated LATENCY-1 times after the operand stage S0.

Test Plan:
- Basic lo: reset, then issue a=0x00E00003, b=0x0000A000, tag=5, hi=0, grant tied 1 -> cdb_req exactly 3 cycles after accept; cdb_tag=5, cdb_data=0x0001E000; done_cnt=1.
- Basic hi: same operands, hi=1 -> cdb_data=0x0000008C. Also a=b=0xFFFFFFFF with hi=1 -> 0xFFFFFFFE, and with hi=0 -> 0x00000001.
- Streaming: 4 consecutive accepts of 0x0000FFFF*0x0000FFFF, tags 1-4, grant=1 -> four consecutive cdb_req cycles, data 0xFFFE0001, tags in order 1,2,3,4.
- Backpressure: grant=0 while 4 ops issued -> busy_cnt=3, in_ready=0 and cdb_req/tag/data stable. Raise grant -> results drain in order, remaining op accepted, no loss or duplication.
- Flush: flush asserted with 3 ops in flight plus a same-cycle in_valid -> next cycle busy_cnt=0, cdb_req=0, done_cnt unchanged. A new op afterwards completes normally.
- Async reset: pull rst_n low mid-stream between clock edges -> cdb_req, busy_cnt, done_cnt, mul_a, mul_b = 0 immediately; in_ready=1 after release.
